regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_if.sv | 38 +++
 rtl/regfile_rd_port.sv | 66 ++++++
 rtl/regfile_param.sv | 114 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parameterised register file:
//   - rf_state_e : clear-sweep FSM states (RF_IDLE, RF_CLEAR)
//   - RF_*       : default values for the DATA_W / ADDR_W / NUM_RD / ZERO_REG
//                  parameters used by regfile_if, regfile_rd_port and
//                  regfile_param
// Optional feature macro used by the design files: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_RD   = 2;
    localparam int RF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if
// Bus bundle between a register-file user (master) and regfile_param (slave).
//   rd_addr  [NUM_RD*ADDR_W] : read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W] : registered read data, port k at [k*DATA_W +: DATA_W]
//   wr_en                    : write enable
//   wr_addr  [ADDR_W]        : write address
//   wr_data  [DATA_W]        : write data, signed two's complement
//   clr_req                  : one-cycle pulse requesting a full-array clear
//   busy                     : high while a clear sweep is running
// -----------------------------------------------------------------------------
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     clr_req;
    logic                     busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, busy
    );

endinterface

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One registered read port of the register file (one-cycle read latency).
//   clk, rst_n  : clock, asynchronous active-low reset (clears the output reg)
//   busy_i      : clear sweep in progress; forces the port output to zero
//   rd_addr_i   : read address for this port
//   mem_word_i  : storage word currently addressed by rd_addr_i
//   wr_fire_i   : a write is committing this cycle   (REGFILE_BYPASS_EN only)
//   wr_addr_i   : address of that write               (REGFILE_BYPASS_EN only)
//   wr_data_i   : data of that write                  (REGFILE_BYPASS_EN only)
//   rd_data_o   : registered read data
// With REGFILE_BYPASS_EN defined, a read hitting the address being written on
// the same edge returns the new data instead of the old register contents.
// -----------------------------------------------------------------------------
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     busy_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        mem_word_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                     wr_fire_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
`endif
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // wr_fire_i is already false for busy and for discarded register-0 writes,
    // so the bypass compare needs no extra qualification here.
    always_comb begin
        rd_d = mem_word_i;
        if (busy_i) begin
            rd_d = '0;
        end else if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_d = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_fire_i && (rd_addr_i == wr_addr_i)) begin
            rd_d = wr_data_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Gating on busy zeroes the port from the first sweep cycle onward, even
    // though rd_q still holds the value captured on the edge that started it.
    assign rd_data_o = busy_i ? '0 : rd_q;

endmodule

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parameterised register file: DEPTH = 2**ADDR_W words of DATA_W bits, one
// write port, NUM_RD registered read ports, optional hardwired-zero register 0
// (ZERO_REG=1), and a one-register-per-cycle clear sweep started by reset or
// by clr_req. While the sweep runs, busy is high, writes and clear requests
// are ignored and every read port returns zero.
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset; restarts the sweep from index 0
//   bus    : regfile_if.slave (rd_addr, rd_data, wr_en, wr_addr, wr_data,
//            clr_req, busy)
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read bypass).
// -----------------------------------------------------------------------------
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_we;
    logic              busy;
    logic              wr_drop_zero;
    logic              wr_fire;

    // Storage carries no reset; it is zeroed only by the sweep.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (bus.clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                clr_we = 1'b1;
                // Stop at the all-ones index rather than relying on wrap.
                if (&idx_q) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign busy         = (state_q == RF_CLEAR);
    assign wr_drop_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign wr_fire      = bus.wr_en && !busy && !wr_drop_zero;
    assign bus.busy     = busy;

    // clr_we and wr_fire are mutually exclusive (wr_fire requires !busy).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[idx_q] <= '0;
        end else if (wr_fire) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = bus.rd_addr[k*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk        (clk),
            .rst_n      (rst_n),
            .busy_i     (busy),
            .rd_addr_i  (addr_k),
            .mem_word_i (mem_q[addr_k]),
`ifdef REGFILE_BYPASS_EN
            .wr_fire_i  (wr_fire),
            .wr_addr_i  (bus.wr_addr),
            .wr_data_i  (bus.wr_data),
`endif
            .rd_data_o  (bus.rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule
